// File: rtl/ex_muldiv_unit_pkg.sv
// ex_muldiv_unit_pkg: shared op encodings, FSM states and default sizes for
// the EX-stage multiply/divide unit.
// Optional MADD support is selected by the MULDIV_MADD_EN macro (see top).
package ex_muldiv_unit_pkg;

  localparam int MULDIV_WIDTH = 32;
  localparam int MULDIV_CNT_W = 6;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_MULT  = 3'b001,
    OP_MULTU = 3'b010,
    OP_DIV   = 3'b011,
    OP_DIVU  = 3'b100,
    OP_MTHI  = 3'b101,
    OP_MTLO  = 3'b110,
    OP_MADD  = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } muldiv_state_e;

endpackage

// File: rtl/ex_muldiv_unit_datapath.sv
// ex_muldiv_unit_datapath: radix-2 shift-add multiplier / restoring divider
// working on operand magnitudes, plus the final sign correction.
// acc_hi_reg:acc_lo_reg is the product register when multiplying and the
// remainder:quotient pair when dividing.
module ex_muldiv_unit_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  logic [WIDTH-1:0]   acc_hi_reg, acc_lo_reg, mcand_reg, a_raw_reg;
  logic               div_mode_reg, neg_q_reg, neg_r_reg, div_zero_reg;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   acc_hi_next, acc_lo_next;
  logic [2*WIDTH-1:0] prod, prod_signed;
  logic [WIDTH-1:0]   quo_signed, rem_signed;

  // Two's-complement magnitudes of the incoming operands (signed ops only).
  always_comb begin
    a_neg = is_signed & opa[WIDTH-1];
    b_neg = is_signed & opb[WIDTH-1];
    mag_a = a_neg ? -opa : opa;
    mag_b = b_neg ? -opb : opb;
  end

  // One iteration: add-then-shift-right for multiply, shift-left-then-trial-
  // subtract for divide. The remainder always stays below the divisor, so
  // WIDTH bits of acc_hi_reg are enough; the shifted-in bit lives in div_shift.
  always_comb begin
    mul_sum   = {1'b0, acc_hi_reg} + {1'b0, {WIDTH{acc_lo_reg[0]}} & mcand_reg};
    div_shift = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, mcand_reg};
    if (div_mode_reg) begin
      acc_hi_next = div_ge ? (div_shift[WIDTH-1:0] - mcand_reg) : div_shift[WIDTH-1:0];
      acc_lo_next = {acc_lo_reg[WIDTH-2:0], div_ge};
    end else begin
      acc_hi_next = mul_sum[WIDTH:1];
      acc_lo_next = {mul_sum[0], acc_lo_reg[WIDTH-1:1]};
    end
  end

  // Sign correction and the divide-by-zero convention (Lo all ones, Hi raw A).
  always_comb begin
    prod        = {acc_hi_reg, acc_lo_reg};
    prod_signed = neg_q_reg ? -prod : prod;
    quo_signed  = neg_q_reg ? -acc_lo_reg : acc_lo_reg;
    rem_signed  = neg_r_reg ? -acc_hi_reg : acc_hi_reg;
    if (!div_mode_reg) begin
      res_hi = prod_signed[2*WIDTH-1:WIDTH];
      res_lo = prod_signed[WIDTH-1:0];
    end else if (div_zero_reg) begin
      res_hi = a_raw_reg;
      res_lo = '1;
    end else begin
      res_hi = rem_signed;
      res_lo = quo_signed;
    end
  end

  // Operand capture on accept, then one iteration per step cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hi_reg   <= '0;
      acc_lo_reg   <= '0;
      mcand_reg    <= '0;
      a_raw_reg    <= '0;
      div_mode_reg <= 1'b0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
    end else if (load) begin
      div_mode_reg <= is_div;
      neg_q_reg    <= a_neg ^ b_neg;
      neg_r_reg    <= a_neg;
      div_zero_reg <= is_div & (opb == '0);
      a_raw_reg    <= opa;
      acc_hi_reg   <= '0;
      acc_lo_reg   <= is_div ? mag_a : mag_b;
      mcand_reg    <= is_div ? mag_b : mag_a;
    end else if (step) begin
      acc_hi_reg <= acc_hi_next;
      acc_lo_reg <= acc_lo_next;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: EX-stage multi-cycle MULT/DIV unit owning HI/LO.
// Sequencing FSM: IDLE -> MUL/DIV (WIDTH iterations) -> FIX (write HI/LO).
// Define MULDIV_MADD_EN to turn op 111 into MADD ({Hi,Lo} += signed A*B);
// otherwise op 111 is ignored like a NOP.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH,
  parameter int CNT_W = MULDIV_CNT_W
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             ReadHiLo,
  input  logic             Flush,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             Stall
);

  muldiv_state_e    state_reg;
  logic [CNT_W-1:0] cnt_reg;
  muldiv_op_e       op;
  logic             op_mul, op_div, op_signed, load, step;
  logic [WIDTH-1:0] res_hi, res_lo;
`ifdef MULDIV_MADD_EN
  logic             madd_reg;
`endif

  // Op decode and datapath handshakes; a flushed Start never loads.
  always_comb begin
    op        = muldiv_op_e'(Op);
    op_mul    = (op == OP_MULT) || (op == OP_MULTU);
    op_div    = (op == OP_DIV) || (op == OP_DIVU);
    op_signed = (op == OP_MULT) || (op == OP_DIV);
`ifdef MULDIV_MADD_EN
    if (op == OP_MADD) begin
      op_mul    = 1'b1;
      op_signed = 1'b1;
    end
`endif
    load = (state_reg == ST_IDLE) && Start && !Flush && (op_mul || op_div);
    step = (state_reg == ST_MUL) || (state_reg == ST_DIV);
  end

  assign Busy  = (state_reg != ST_IDLE);
  assign Done  = (state_reg == ST_FIX) && !Flush;
  assign Stall = Busy & (Start | ReadHiLo);

  ex_muldiv_unit_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk       (Clk),
    .rst_n     (Rst_n),
    .load      (load),
    .step      (step),
    .is_div    (op_div),
    .is_signed (op_signed),
    .opa       (OperandA),
    .opb       (OperandB),
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );

  // Control FSM, iteration counter and the architectural HI/LO registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      Hi        <= '0;
      Lo        <= '0;
`ifdef MULDIV_MADD_EN
      madd_reg  <= 1'b0;
`endif
    end else if (Flush) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (Start) begin
            cnt_reg <= '0;
            if (op_mul)              state_reg <= ST_MUL;
            else if (op_div)         state_reg <= ST_DIV;
            else if (op == OP_MTHI)  Hi <= OperandA;
            else if (op == OP_MTLO)  Lo <= OperandA;
`ifdef MULDIV_MADD_EN
            madd_reg <= (op == OP_MADD);
`endif
          end
        end
        ST_MUL, ST_DIV: begin
          if (cnt_reg == CNT_W'(WIDTH - 1)) begin
            state_reg <= ST_FIX;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_FIX: begin
          Hi <= res_hi;
          Lo <= res_lo;
`ifdef MULDIV_MADD_EN
          if (madd_reg) {Hi, Lo} <= {Hi, Lo} + {res_hi, res_lo};
`endif
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage, fed directly by the ID/EX pipeline register outputs (operands and mul/div control); owns the architectural HI/LO registers.
- Radix-2 iterative engine (shift-add multiply, restoring divide); raises stall so the hazard logic freezes IF/ID/ID-EX while busy or when HI/LO reads or writes collide with a running operation.

Parameters:
- WIDTH, 32, operand/HI/LO width (even, >=8)
- CNT_W, 6, iteration counter width; must hold WIDTH

Ports:
- Clk  in  1  clock, rising edge
- Rst_n  in  1  asynchronous active-low reset
- Start  in  1  valid mul/div-class op in EX this cycle (from ID/EX)
- Op  in  3  000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 MADD
- OperandA  in  WIDTH  rs value (forwarded)
- OperandB  in  WIDTH  rt value (forwarded)
- ReadHiLo  in  1  MFHI/MFLO in EX this cycle
- Flush  in  1  squash op in flight (branch/exception)
- Hi  out  WIDTH  HI register
- Lo  out  WIDTH  LO register
- Busy  out  1  engine running
- Done  out  1  one-cycle pulse in the cycle HI/LO are written by mul/div
- Stall  out  1  Busy & (Start | ReadHiLo)

Behaviour:
- Reset (async, Rst_n=0): state IDLE, Hi=Lo=0, Busy=Done=Stall=0, counter and datapath registers 0.
- States: IDLE, MUL, DIV, FIX.
- IDLE, Start=1:
  - MULT/MULTU -> MUL; DIV/DIVU -> DIV. Latch magnitudes (signed ops: two's-complement abs) and result signs; counter=0.
  - MTHI/MTLO: Hi/Lo <= OperandA at the edge; stay IDLE; no Done.
  - NOP, or 111 without macro: ignored.
- MUL/DIV: one iteration per cycle for WIDTH cycles, counter 0..WIDTH-1; then -> FIX.
- FIX: apply sign correction, write Hi/Lo, Done=1, -> IDLE.
- Latency: Start at cycle 0; Busy=1 cycles 1..WIDTH+1; Done in cycle WIDTH+1; new Hi/Lo visible at cycle WIDTH+2 (34 at default). Back-to-back Start in cycle WIDTH+2 is accepted.
- Start while Busy: Stall=1; op held by the pipeline and accepted once Busy drops.
- ReadHiLo while Busy: Stall=1. ReadHiLo in IDLE: no stall; Hi/Lo hold old values.
- Arithmetic:
  - Multiply: 2*WIDTH-bit product, Hi=upper, Lo=lower.
  - Signed product negated when sign(A)^sign(B).
  - Divide: Lo=quotient, Hi=remainder.
  - Signed: quotient negated when sign(A)^sign(B); remainder takes the sign of A (truncation toward zero).
- Divide by zero (B=0, signed or unsigned): Lo=all ones, Hi=OperandA as latched (raw); full WIDTH+1 cycle latency preserved.
- Signed overflow (-2^(W-1) / -1): Lo=0x80000000, Hi=0; no trap.
- Flush: returns to IDLE next edge from any state; Hi/Lo unchanged; no Done.
  - Flush with Start in IDLE: op discarded.
  - Flush in FIX: write suppressed.
- Reset mid-operation: immediate abort; all outputs to reset values.

Optional Feature:
- Macro: MULDIV_MADD_EN
- Defined: Op 111 = MADD, a signed multiply taking the MUL path; in FIX, {Hi,Lo} <= {Hi,Lo} + signed product (wraps modulo 2^(2*WIDTH)).
- Undefined: Op 111 treated as NOP, no accumulate adder synthesized.

Decomposition:
- Shared package (pipeline defs): Op encodings, state encoding, WIDTH default.
- One natural sub-module: muldiv_datapath (shift/add/subtract registers, abs/negate), controlled by the ex_muldiv_unit FSM and counter.

Test Plan:
- Reset values:
  - Rst_n low mid-MUL (cycle 10) -> Hi=Lo=0, Busy=0 immediately.
  - Fresh MULT 2*3 afterwards -> Lo=6, Hi=0.
- MULT -3 * 7, Start cycle 0:
  - Busy cycles 1..33; Done cycle 33.
  - Cycle 34: Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
- DIVU 100/7:
  - Lo=14, Hi=2.
- DIV -7/2:
  - Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- DIV 5/0:
  - Lo=0xFFFFFFFF, Hi=5.
- Stall:
  - ReadHiLo asserted cycles 5..40 after a MULT -> Stall=1 through cycle 33, 0 from cycle 34.
  - Flush at cycle 12 -> IDLE, Hi/Lo keep prior values, no Done.
  - With MULDIV_MADD_EN: Hi:Lo=0:10, MADD 4*5 -> Lo=30.
